// File: rtl/rr_arb4_pkg.sv
// Shared constants, grant record and round-robin search helper for rr_arb4.
package rr_arb4_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    // Reset value of the last-grant pointer: requester 0 is searched first.
    localparam logic [SEL_W-1:0] PTR_RESET = SEL_W'(N_REQ - 1);

    // Result of one round-robin search.
    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } grant_t;

    // First requester with valid set, scanning ptr+1 .. ptr+N_REQ (mod N_REQ).
    function automatic grant_t rr_pick(input logic [N_REQ-1:0] valid,
                                       input logic [SEL_W-1:0] ptr);
        grant_t           g;
        logic [SEL_W-1:0] idx;
        g.found = 1'b0;
        g.idx   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!g.found && valid[idx]) begin
                g.found = 1'b1;
                g.idx   = idx;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arb4_mux4.sv
// Four-way payload multiplexer used by rr_arb4 to pick the granted requester.
module mux4
    import rr_arb4_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic [WIDTH-1:0] d2_i,
    input  logic [WIDTH-1:0] d3_i,
    output logic [WIDTH-1:0] res_o
);

    // Select one of the four payloads.
    always_comb begin
        res_o = d0_i;
        case (sel_i)
            2'd1:    res_o = d1_i;
            2'd2:    res_o = d2_i;
            2'd3:    res_o = d3_i;
            default: res_o = d0_i;
        endcase
    end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with a single registered output slot.
// The output register reloads whenever it is empty or being drained, so a
// continuously ready sink sees one beat per cycle with no bubbles.
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic [WIDTH-1:0] d2_i,
    input  logic [WIDTH-1:0] d3_i,
    input  logic [N_REQ-1:0] valid_i,
    output logic [N_REQ-1:0] ready_o,
    output logic [WIDTH-1:0] res_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [SEL_W-1:0] sel_o
);

    logic [SEL_W-1:0] ptr_q;
    logic             load_c;
    grant_t           grant_c;
    logic [WIDTH-1:0] mux_c;

    // Output slot may take a new beat when empty or drained this cycle.
    always_comb begin
        load_c  = !res_valid_o || res_ready_i;
        grant_c = rr_pick(valid_i, ptr_q);
        ready_o = '0;
        // Reset also blocks acceptance so nothing is lost while held in reset.
        if (arst_n_i && load_c && grant_c.found) begin
            ready_o[grant_c.idx] = 1'b1;
        end
    end

    mux4 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel_i (grant_c.idx),
        .d0_i  (d0_i),
        .d1_i  (d1_i),
        .d2_i  (d2_i),
        .d3_i  (d3_i),
        .res_o (mux_c)
    );

    // Output register and last-grant pointer; both hold during a stall.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            res_o       <= '0;
            sel_o       <= '0;
            res_valid_o <= 1'b0;
            ptr_q       <= PTR_RESET;
        end else if (load_c) begin
            if (grant_c.found) begin
                res_o       <= mux_c;
                sel_o       <= grant_c.idx;
                res_valid_o <= 1'b1;
                ptr_q       <= grant_c.idx;
            end else begin
                res_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: a directed vector table, a reset-in-stall sequence and a
// randomised phase checked against a reference arbiter through a queue.
module tb_rr_arb4;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         arst_n;
    logic [W-1:0] d [4];
    logic [3:0]   valid;
    logic [3:0]   ready;
    logic [W-1:0] res;
    logic         res_valid;
    logic         res_ready;
    logic [1:0]   sel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_arb4 #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .d0_i        (d[0]),
        .d1_i        (d[1]),
        .d2_i        (d[2]),
        .d3_i        (d[3]),
        .valid_i     (valid),
        .ready_o     (ready),
        .res_o       (res),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .sel_o       (sel)
    );

    typedef struct {
        logic [3:0]   valid;
        logic         rr;
        logic [3:0]   exp_ready;
        logic         exp_rv;
        logic [W-1:0] exp_res;
        logic [1:0]   exp_sel;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic [1:0]   sel;
    } beat_t;

    vec_t  vt[$];
    beat_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic rr, input logic [3:0] er,
                       input logic rv, input logic [W-1:0] r, input logic [1:0] s);
        vec_t x;
        x.valid = v; x.rr = rr; x.exp_ready = er;
        x.exp_rv = rv; x.exp_res = r; x.exp_sel = s;
        vt.push_back(x);
    endtask

    // Reference model state for the randomised phase.
    logic [1:0] ptr_m;
    logic       rv_m;

    initial begin
        logic [3:0] exp_rdy;
        logic       load_m;
        logic       found;
        int         g;
        beat_t      b;

        arst_n    = 1'b0;
        d[0] = 8'hAA; d[1] = 8'hBB; d[2] = 8'hCC; d[3] = 8'hDD;
        valid     = 4'b1111;
        res_ready = 1'b1;

        // Reset state, with all requesters asserting.
        repeat (2) @(posedge clk);
        #1;
        chk("reset res_valid", 32'(res_valid), 32'(0));
        chk("reset res", 32'(res), 32'(0));
        chk("reset sel", 32'(sel), 32'(0));
        chk("reset ready", 32'(ready), 32'(0));
        @(negedge clk);
        arst_n = 1'b1;
        valid  = 4'b0000;
        @(posedge clk);
        #1;
        chk("idle after reset", 32'(res_valid), 32'(0));

        // Full rotation from reset.
        add(4'b1111, 1, 4'b0001, 1, 8'hAA, 0);
        add(4'b1111, 1, 4'b0010, 1, 8'hBB, 1);
        add(4'b1111, 1, 4'b0100, 1, 8'hCC, 2);
        add(4'b1111, 1, 4'b1000, 1, 8'hDD, 3);
        add(4'b1111, 1, 4'b0001, 1, 8'hAA, 0);
        // Stall for three cycles, then release.
        add(4'b1111, 0, 4'b0000, 1, 8'hAA, 0);
        add(4'b1111, 0, 4'b0000, 1, 8'hAA, 0);
        add(4'b1111, 0, 4'b0000, 1, 8'hAA, 0);
        add(4'b1111, 1, 4'b0010, 1, 8'hBB, 1);
        // Sole requester granted every cycle.
        for (int i = 0; i < 4; i++) add(4'b0100, 1, 4'b0100, 1, 8'hCC, 2);
        // Wrap-around between requesters 3 and 0.
        add(4'b1000, 1, 4'b1000, 1, 8'hDD, 3);
        add(4'b1001, 1, 4'b0001, 1, 8'hAA, 0);
        add(4'b1001, 1, 4'b1000, 1, 8'hDD, 3);
        add(4'b1001, 1, 4'b0001, 1, 8'hAA, 0);
        // Drain to empty; output holds last beat.
        add(4'b0000, 1, 4'b0000, 0, 8'hAA, 0);
        add(4'b0000, 0, 4'b0000, 0, 8'hAA, 0);
        // Empty slot loads even with sink not ready.
        add(4'b0010, 0, 4'b0010, 1, 8'hBB, 1);
        // Requesters withdraw during a stall; pointer must stay on 1.
        add(4'b1100, 0, 4'b0000, 1, 8'hBB, 1);
        add(4'b0000, 1, 4'b0000, 0, 8'hBB, 1);
        add(4'b1111, 1, 4'b0100, 1, 8'hCC, 2);

        foreach (vt[i]) begin
            valid     = vt[i].valid;
            res_ready = vt[i].rr;
            @(negedge clk);
            chk($sformatf("vec%0d ready", i), 32'(ready), 32'(vt[i].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d res_valid", i), 32'(res_valid), 32'(vt[i].exp_rv));
            chk($sformatf("vec%0d res", i), 32'(res), 32'(vt[i].exp_res));
            chk($sformatf("vec%0d sel", i), 32'(sel), 32'(vt[i].exp_sel));
        end

        // Reset asserted while a beat is held in a stall.
        valid     = 4'b1111;
        res_ready = 1'b0;
        @(negedge clk);
        chk("stall before reset", 32'(res_valid), 32'(1));
        #2;
        arst_n = 1'b0;
        #1;
        chk("async reset res_valid", 32'(res_valid), 32'(0));
        chk("async reset res", 32'(res), 32'(0));
        chk("async reset sel", 32'(sel), 32'(0));
        chk("ready in reset", 32'(ready), 32'(0));
        @(negedge clk);
        arst_n    = 1'b1;
        res_ready = 1'b1;
        #1;
        chk("first grant ready", 32'(ready), 32'(4'b0001));
        @(posedge clk);
        #1;
        chk("first grant res", 32'(res), 32'(8'hAA));
        chk("first grant sel", 32'(sel), 32'(0));
        chk("first grant valid", 32'(res_valid), 32'(1));

        // Randomised phase against a reference model and scoreboard queue.
        ptr_m = 2'd0;
        rv_m  = 1'b1;
        b.res = 8'hAA; b.sel = 2'd0;
        sb.push_back(b);
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int k = 0; k < 4; k++) d[k] = W'($urandom_range(0, 255));
            valid     = 4'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            load_m  = !rv_m || res_ready;
            found   = 1'b0;
            g       = 0;
            for (int s = 1; s <= 4; s++) begin
                int k;
                k = (int'(ptr_m) + s) % 4;
                if (!found && valid[k]) begin
                    found = 1'b1;
                    g     = k;
                end
            end
            exp_rdy = '0;
            if (load_m && found) exp_rdy[g] = 1'b1;
            chk("rand ready", 32'(ready), 32'(exp_rdy));
            chk("rand res_valid", 32'(res_valid), 32'(rv_m));
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("rand unexpected beat", 32'(1), 32'(0));
                end else begin
                    b = sb.pop_front();
                    chk("rand res", 32'(res), 32'(b.res));
                    chk("rand sel", 32'(sel), 32'(b.sel));
                end
            end
            if (load_m) begin
                if (found) begin
                    b.res = d[g];
                    b.sel = 2'(g);
                    sb.push_back(b);
                    ptr_m = 2'(g);
                    rv_m  = 1'b1;
                end else begin
                    rv_m = 1'b0;
                end
            end
            @(posedge clk);
            #1;
        end
        chk("scoreboard residue", 32'(sb.size()), 32'(rv_m ? 1 : 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 Parameter WIDTH, default 8, data width of each requester and of the output.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 arst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 d0_i, d1_i, d2_i, d3_i  input  WIDTH each  requester payloads.
REQ-005 valid_i  input  4  bit k = requester k has payload on dk_i.
REQ-006 ready_o  output  4  bit k = payload of requester k accepted this cycle.
REQ-007 res_o  output  WIDTH  registered selected payload.
REQ-008 res_valid_o  output  1  res_o holds a valid payload.
REQ-009 res_ready_i  input  1  downstream accepts res_o this cycle.
REQ-010 sel_o  output  2  index of the requester whose payload is in res_o.

Function
REQ-011 Transfer on a requester side SHALL occur when valid_i[k] and ready_o[k] are both 1 at a rising edge; transfer on the output side when res_valid_o and res_ready_i are both 1.
REQ-012 load = !res_valid_o || res_ready_i; the output register SHALL update only when load is 1.
REQ-013 Grant g SHALL be the first k with valid_i[k]=1, searching ptr+1, ptr+2, ptr+3, ptr (mod 4), where ptr is a 2-bit last-grant register.
REQ-014 ready_o SHALL be one-hot or zero: ready_o[g]=1 only when load=1 and |valid_i=1; combinational from valid_i, ptr, res_valid_o, res_ready_i.
REQ-015 On load with |valid_i=1: res_o<=dg_i, sel_o<=g, res_valid_o<=1, ptr<=g.
REQ-016 On load with valid_i=0: res_valid_o<=0; res_o, sel_o, ptr SHALL hold.
REQ-017 When load=0 (stall): res_o, sel_o, res_valid_o, ptr SHALL hold; ready_o SHALL be 0.
REQ-018 Latency: payload accepted at edge N appears on res_o with res_valid_o=1 after edge N; full throughput of one transfer per cycle when res_ready_i=1 continuously.
REQ-019 Simultaneous output accept and new grant in the same cycle SHALL produce back-to-back valid beats with no bubble.
REQ-020 A sole active requester SHALL be granted on every load cycle (no forced gap after its own grant).
REQ-021 Requesters withdrawing valid_i before being granted SHALL NOT corrupt ptr or output.
REQ-022 Fairness: with all four continuously valid, grants SHALL rotate strictly; no requester waits more than 3 grants.
REQ-023 ptr wrap-around: after grant 3 the search SHALL start at 0.

Reset
REQ-024 On arst_n_i=0, asynchronously: res_valid_o=0, res_o=0, sel_o=0, ptr=3 (so requester 0 has first priority).
REQ-025 Reset mid-transfer SHALL discard the held payload; ready_o SHALL be 0 while arst_n_i=0.
REQ-026 Release of reset SHALL take effect at the next rising edge; first grant possible on that edge.

Structure
REQ-027 Package rr_arb4_pkg SHALL hold N_REQ=4 and SEL_W=2 constants.
REQ-028 Payload selection SHALL instantiate existing mux4 (WIDTH passed through, sel_i driven by g, res_o feeding the output register).
REQ-029 Grant search, ptr register and output register SHALL live in rr_arb4 itself.

Verification
REQ-030 Reset, d0..d3=AA,BB,CC,DD, valid_i=1111, res_ready_i=1 -> res_o AA,BB,CC,DD,AA on successive cycles, sel_o 0,1,2,3,0.
REQ-031 valid_i=0100 only, res_ready_i=1 for 4 cycles -> ready_o=0100 every cycle, res_o=CC, sel_o=2, res_valid_o=1 continuously.
REQ-032 valid_i=1111, res_ready_i=0 after first beat for 3 cycles -> res_o=AA held, ready_o=0000 during stall; on release next beat BB.
REQ-033 After grant 3 (ptr=3), valid_i=1001 -> next grant 0 then 3 (wrap-around).
REQ-034 valid_i=0000 with res_ready_i=1 after a beat -> res_valid_o falls to 0, res_o/sel_o hold last value.
REQ-035 Assert arst_n_i=0 while res_valid_o=1 with stall -> res_valid_o=0, res_o=0 immediately; after release with valid_i=1111 first grant is 0.
